dasm_mips: RTL and testbench

Debug disassembler for the pipelined MIPS core. Each cycle it samples a 32-bit instruction word and its PC, then renders the instruction as fixed-width ASCII text (32 characters) for waveform and log inspection. Pipeline registers instantiate it on their stage outputs. It has no effect on architectural state.

---
 rtl/dasm_pkg.sv | 94 +++++++++
 rtl/dasm_mips_if.sv | 10 +
 rtl/dasm_fmt.sv | 97 +++++++++
 rtl/dasm_mips.sv | 111 +++++++++++
 tb/tb_dasm_mips.sv | 127 ++++++++++++
 5 files changed

// File: rtl/dasm_pkg.sv
// Shared constants, types and helpers for the MIPS debug disassembler.
package dasm_pkg;

  localparam logic [7:0] Space = 8'h20;

  localparam logic [5:0] OpcSpecial = 6'h00;
  localparam logic [5:0] OpcJ       = 6'h02;
  localparam logic [5:0] OpcJal     = 6'h03;
  localparam logic [5:0] OpcBeq     = 6'h04;
  localparam logic [5:0] OpcBne     = 6'h05;
  localparam logic [5:0] OpcAddiu   = 6'h09;
  localparam logic [5:0] OpcAndi    = 6'h0c;
  localparam logic [5:0] OpcOri     = 6'h0d;
  localparam logic [5:0] OpcLui     = 6'h0f;
  localparam logic [5:0] OpcLw      = 6'h23;
  localparam logic [5:0] OpcSw      = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2a;

  // Mnemonics are 7 characters, space padded; the formatter stops at the first space.
  localparam logic [55:0] MnNop     = "nop    ";
  localparam logic [55:0] MnUnknown = "unknown";
  localparam logic [55:0] MnAddu    = "addu   ";
  localparam logic [55:0] MnSubu    = "subu   ";
  localparam logic [55:0] MnAnd     = "and    ";
  localparam logic [55:0] MnOr      = "or     ";
  localparam logic [55:0] MnSlt     = "slt    ";
  localparam logic [55:0] MnSll     = "sll    ";
  localparam logic [55:0] MnSrl     = "srl    ";
  localparam logic [55:0] MnJr      = "jr     ";
  localparam logic [55:0] MnJalr    = "jalr   ";
  localparam logic [55:0] MnOri     = "ori    ";
  localparam logic [55:0] MnAndi    = "andi   ";
  localparam logic [55:0] MnAddiu   = "addiu  ";
  localparam logic [55:0] MnLui     = "lui    ";
  localparam logic [55:0] MnLw      = "lw     ";
  localparam logic [55:0] MnSw      = "sw     ";
  localparam logic [55:0] MnBeq     = "beq    ";
  localparam logic [55:0] MnBne     = "bne    ";
  localparam logic [55:0] MnJ       = "j      ";
  localparam logic [55:0] MnJal     = "jal    ";

  localparam logic [31:0] AbiName [32] = '{
    "zero", "at  ", "v0  ", "v1  ", "a0  ", "a1  ", "a2  ", "a3  ",
    "t0  ", "t1  ", "t2  ", "t3  ", "t4  ", "t5  ", "t6  ", "t7  ",
    "s0  ", "s1  ", "s2  ", "s3  ", "s4  ", "s5  ", "s6  ", "s7  ",
    "t8  ", "t9  ", "k0  ", "k1  ", "gp  ", "sp  ", "fp  ", "ra  "
  };

  typedef enum logic [2:0] {OpNone, OpReg, OpDec, OpHex4, OpHex8} opnd_kind_e;

  typedef struct packed {
    opnd_kind_e  kind;
    logic [31:0] val;
  } opnd_t;

  // mem_form renders operand 2 as "(reg)" with no comma before it.
  typedef struct packed {
    logic [55:0]     mnem;
    opnd_t [2:0]     ops;
    logic            mem_form;
  } dis_t;

  typedef struct packed {
    logic [79:0] chars;
    logic [3:0]  len;
  } tok_t;

  typedef struct packed {
    logic [255:0] chars;
    logic [5:0]   len;
  } line_t;

  function automatic logic [7:0] hex_char(logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic opnd_t op_reg(logic [4:0] r);
    return '{kind: OpReg, val: {27'd0, r}};
  endfunction

  function automatic opnd_t op_val(opnd_kind_e k, logic [31:0] v);
    return '{kind: k, val: v};
  endfunction

endpackage

// File: rtl/dasm_mips_if.sv
// Sampled instruction inputs and rendered text output of the disassembler.
interface dasm_mips_if;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         reg_name;
  logic [255:0] asm;

  modport master (output pc, output instr, output reg_name, input asm);
  modport slave  (input pc, input instr, input reg_name, output asm);
endinterface

// File: rtl/dasm_fmt.sv
// Combinational text assembly: mnemonic plus up to three rendered operands.
module dasm_fmt
  import dasm_pkg::*;
(
  input  dis_t         dis_i,
  input  logic         abi_i,
  output logic [255:0] text_o
);

  function automatic tok_t push(tok_t t, logic [7:0] ch);
    tok_t r = t;
    if (r.len < 4'd10) begin
      r.chars[79 - 8 * r.len -: 8] = ch;
      r.len = r.len + 4'd1;
    end
    return r;
  endfunction

  function automatic line_t put(line_t l, logic [7:0] ch);
    line_t r = l;
    if (r.len < 6'd32) begin
      r.chars[255 - 8 * r.len -: 8] = ch;
      r.len = r.len + 6'd1;
    end
    return r;
  endfunction

  function automatic tok_t render(opnd_t o, logic abi);
    tok_t        t;
    logic [31:0] nm;
    logic [4:0]  r;
    logic [1:0]  tens;
    logic [4:0]  ones;
    int          n;
    t.chars = {10{Space}};
    t.len   = '0;
    r       = o.val[4:0];
    nm      = AbiName[r];
    tens    = (r >= 5'd30) ? 2'd3 : (r >= 5'd20) ? 2'd2 : (r >= 5'd10) ? 2'd1 : 2'd0;
    ones    = r - {tens, 3'b000} - {2'b00, tens, 1'b0};
    n       = (o.kind == OpHex8) ? 8 : 4;
    case (o.kind)
      OpReg, OpDec: begin
        if (o.kind == OpReg) t = push(t, "$");
        if (o.kind == OpReg && abi) begin
          for (int k = 0; k < 4; k++) begin
            if (nm[31 - 8 * k -: 8] != Space) t = push(t, nm[31 - 8 * k -: 8]);
          end
        end else begin
          if (tens != 2'd0) t = push(t, hex_char({2'b00, tens}));
          t = push(t, hex_char(ones[3:0]));
        end
      end
      OpHex4, OpHex8: begin
        t = push(t, "0");
        t = push(t, "x");
        for (int k = 7; k >= 0; k--) begin
          if (k < n) t = push(t, hex_char(o.val[4 * k +: 4]));
        end
      end
      default: ;
    endcase
    return t;
  endfunction

  line_t      line;
  tok_t       tok;
  logic       stop;
  logic [7:0] ch;

  always_comb begin
    line.chars = {32{Space}};
    line.len   = '0;
    tok        = '0;
    stop       = 1'b0;
    ch         = Space;
    for (int k = 0; k < 7; k++) begin
      ch = dis_i.mnem[55 - 8 * k -: 8];
      if (ch == Space) stop = 1'b1;
      if (!stop) line = put(line, ch);
    end
    for (int i = 0; i < 3; i++) begin
      if (dis_i.ops[i].kind != OpNone) begin
        if (i == 0)                       line = put(line, " ");
        else if (dis_i.mem_form && i == 2) line = put(line, "(");
        else                              line = put(line, ",");
        tok = render(dis_i.ops[i], abi_i);
        for (int k = 0; k < 10; k++) begin
          if (k < int'(tok.len)) line = put(line, tok.chars[79 - 8 * k -: 8]);
        end
        if (dis_i.mem_form && i == 2) line = put(line, ")");
      end
    end
    text_o = line.chars;
  end

endmodule

// File: rtl/dasm_mips.sv
// Debug disassembler: decodes a MIPS instruction word and registers its ASCII rendering.
module dasm_mips
  import dasm_pkg::*;
(
  input logic        clk,
  input logic        reset,
  dasm_mips_if.slave bus
);

  logic [5:0]   opcode, funct;
  logic [4:0]   rs, rt, rd, shamt;
  logic [31:0]  imm_z, pc4, br_target, j_target;
  dis_t         dis;
  logic [255:0] asm_d, asm_q;

  assign opcode    = bus.instr[31:26];
  assign rs        = bus.instr[25:21];
  assign rt        = bus.instr[20:16];
  assign rd        = bus.instr[15:11];
  assign shamt     = bus.instr[10:6];
  assign funct     = bus.instr[5:0];
  assign imm_z     = {16'd0, bus.instr[15:0]};
  assign pc4       = bus.pc + 32'd4;
  assign br_target = pc4 + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
  assign j_target  = {pc4[31:28], bus.instr[25:0], 2'b00};

  always_comb begin
    dis.mnem     = MnUnknown;
    dis.ops      = '0;
    dis.mem_form = 1'b0;
    // All-zero word is sll $0,$0,0; show it as nop instead.
    if (bus.instr == 32'd0) begin
      dis.mnem = MnNop;
    end else begin
      case (opcode)
        OpcSpecial: begin
          case (funct)
            FnAddu, FnSubu, FnAnd, FnOr, FnSlt: begin
              dis.mnem = (funct == FnAddu) ? MnAddu :
                         (funct == FnSubu) ? MnSubu :
                         (funct == FnAnd)  ? MnAnd  :
                         (funct == FnOr)   ? MnOr   : MnSlt;
              dis.ops[0] = op_reg(rd);
              dis.ops[1] = op_reg(rs);
              dis.ops[2] = op_reg(rt);
            end
            FnSll, FnSrl: begin
              dis.mnem   = (funct == FnSll) ? MnSll : MnSrl;
              dis.ops[0] = op_reg(rd);
              dis.ops[1] = op_reg(rt);
              dis.ops[2] = op_val(OpDec, {27'd0, shamt});
            end
            FnJr: begin
              dis.mnem   = MnJr;
              dis.ops[0] = op_reg(rs);
            end
            FnJalr: begin
              dis.mnem   = MnJalr;
              dis.ops[0] = op_reg(rd);
              dis.ops[1] = op_reg(rs);
            end
            default: ;
          endcase
        end
        OpcOri, OpcAndi, OpcAddiu: begin
          dis.mnem   = (opcode == OpcOri) ? MnOri : (opcode == OpcAndi) ? MnAndi : MnAddiu;
          dis.ops[0] = op_reg(rt);
          dis.ops[1] = op_reg(rs);
          dis.ops[2] = op_val(OpHex4, imm_z);
        end
        OpcLui: begin
          dis.mnem   = MnLui;
          dis.ops[0] = op_reg(rt);
          dis.ops[1] = op_val(OpHex4, imm_z);
        end
        OpcLw, OpcSw: begin
          dis.mnem     = (opcode == OpcLw) ? MnLw : MnSw;
          dis.ops[0]   = op_reg(rt);
          dis.ops[1]   = op_val(OpHex4, imm_z);
          dis.ops[2]   = op_reg(rs);
          dis.mem_form = 1'b1;
        end
        OpcBeq, OpcBne: begin
          dis.mnem   = (opcode == OpcBeq) ? MnBeq : MnBne;
          dis.ops[0] = op_reg(rs);
          dis.ops[1] = op_reg(rt);
          dis.ops[2] = op_val(OpHex8, br_target);
        end
        OpcJ, OpcJal: begin
          dis.mnem   = (opcode == OpcJ) ? MnJ : MnJal;
          dis.ops[0] = op_val(OpHex8, j_target);
        end
        default: ;
      endcase
    end
  end

  dasm_fmt u_fmt (
    .dis_i  (dis),
    .abi_i  (bus.reg_name),
    .text_o (asm_d)
  );

  always_ff @(posedge clk) begin
    if (reset) asm_q <= {32{Space}};
    else       asm_q <= asm_d;
  end

  assign bus.asm = asm_q;

endmodule

// File: tb/tb_dasm_mips.sv
// Self-checking bench for dasm_mips: vector table driven through a one-cycle scoreboard.
module tb_dasm_mips;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dasm_mips_if bus ();

  dasm_mips dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rn;
    string       exp;
  } vec_t;

  typedef struct {
    logic [255:0] exp;
    string        name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [255:0] to_text(string s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255 - 8 * i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  task automatic add(logic rst, logic [31:0] pc, logic [31:0] instr, logic rn, string exp);
    vec_t v;
    v.rst = rst; v.pc = pc; v.instr = instr; v.rn = rn; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check_front();
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.asm !== e.exp) begin
        errors++;
        $display("FAIL %s: got \"%s\" expected \"%s\"", e.name, bus.asm, e.exp);
      end
    end
  endtask

  // One cycle: compare what was driven last cycle, then drive the next vector.
  task automatic drive(vec_t v, string name);
    sb_t e;
    @(negedge clk);
    check_front();
    reset        = v.rst;
    bus.pc       = v.pc;
    bus.instr    = v.instr;
    bus.reg_name = v.rn;
    e.exp  = to_text(v.rst ? "" : v.exp);
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    vec_t v;
    reset        = 1'b1;
    bus.pc       = '0;
    bus.instr    = '0;
    bus.reg_name = 1'b0;

    add(1'b1, 32'h0000_0000, 32'h0022_1821, 1'b0, "");
    add(1'b1, 32'h0000_0000, 32'h0022_1821, 1'b1, "");
    add(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, "nop");
    add(1'b0, 32'h0000_0000, 32'h0022_1821, 1'b0, "addu $3,$1,$2");
    add(1'b0, 32'h0000_0000, 32'h0022_1821, 1'b1, "addu $v1,$at,$v0");
    add(1'b0, 32'h0000_0000, 32'h3408_0010, 1'b0, "ori $8,$0,0x0010");
    add(1'b0, 32'h0000_0000, 32'h8fa4_0004, 1'b1, "lw $a0,0x0004($sp)");
    add(1'b0, 32'h0000_3000, 32'h1000_ffff, 1'b0, "beq $0,$0,0x00003000");
    add(1'b0, 32'h0000_3004, 32'h0c00_0c10, 1'b0, "jal 0x00003040");
    add(1'b0, 32'h0000_0000, 32'h0008_4080, 1'b0, "sll $8,$8,2");
    add(1'b0, 32'h0000_0000, 32'h03e0_0008, 1'b0, "jr $31");
    add(1'b0, 32'h0000_0000, 32'hfc00_0000, 1'b0, "unknown");
    add(1'b0, 32'h0000_3000, 32'h1000_ffff, 1'b1, "beq $zero,$zero,0x00003000");
    add(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, "nop");
    add(1'b0, 32'hffff_fffc, 32'h1422_0001, 1'b0, "bne $1,$2,0x00000004");
    add(1'b0, 32'hf000_0000, 32'h0bff_ffff, 1'b0, "j 0xfffffffc");
    add(1'b0, 32'h0000_0000, 32'h0060_f809, 1'b1, "jalr $ra,$v1");
    add(1'b0, 32'h0000_0000, 32'h0000_0040, 1'b0, "sll $0,$0,1");
    add(1'b0, 32'h0000_0000, 32'h0008_47c2, 1'b0, "srl $8,$8,31");
    add(1'b0, 32'h0000_0000, 32'h3c1d_abcd, 1'b1, "lui $sp,0xabcd");
    add(1'b0, 32'h0000_0000, 32'hafbf_0010, 1'b1, "sw $ra,0x0010($sp)");
    add(1'b0, 32'h0000_0000, 32'h0149_5023, 1'b1, "subu $t2,$t2,$t1");
    add(1'b0, 32'h0000_0000, 32'h0109_602a, 1'b0, "slt $12,$8,$9");
    add(1'b0, 32'h0000_0000, 32'h0085_1024, 1'b0, "and $2,$4,$5");
    add(1'b0, 32'h0000_0000, 32'h0211_9025, 1'b1, "or $s2,$s0,$s1");
    add(1'b0, 32'h0000_0000, 32'h271c_fff0, 1'b1, "addiu $gp,$t8,0xfff0");
    add(1'b0, 32'h0000_0000, 32'h30a5_ff00, 1'b0, "andi $5,$5,0xff00");
    add(1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, "unknown");

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i], $sformatf("vec%0d", i));

    // Mid-stream reset overrides a live instruction, then decoding resumes.
    v.rst = 1'b0; v.pc = 32'h0; v.instr = 32'h3c1d_abcd; v.rn = 1'b0; v.exp = "lui $29,0xabcd";
    drive(v, "pre_reset");
    v.rst = 1'b1; v.instr = 32'h0022_1821; v.exp = "";
    drive(v, "mid_reset");
    v.rst = 1'b0; v.instr = 32'h03e0_0008; v.rn = 1'b1; v.exp = "jr $ra";
    drive(v, "post_reset");
    // Same input held for two cycles renders identically both times.
    drive(v, "hold");

    @(negedge clk);
    check_front();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
